// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared encodings for the CPU controller: FSM states, opcodes,
//               ALU operation selects.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_FETCH  = 3'd1;
    localparam logic [2:0] c_ST_DECODE = 3'd2;
    localparam logic [2:0] c_ST_EXEC   = 3'd3;
    localparam logic [2:0] c_ST_WB     = 3'd4;
    localparam logic [2:0] c_ST_HALT   = 3'd5;

    localparam logic [2:0] c_OP_NOP  = 3'b000;
    localparam logic [2:0] c_OP_ADD  = 3'b001;
    localparam logic [2:0] c_OP_SUB  = 3'b010;
    localparam logic [2:0] c_OP_AND  = 3'b011;
    localparam logic [2:0] c_OP_BEQ  = 3'b100;
    localparam logic [2:0] c_OP_LDI  = 3'b101;
    localparam logic [2:0] c_OP_NOP2 = 3'b110;
    localparam logic [2:0] c_OP_HLT  = 3'b111;

    localparam logic [1:0] c_ALU_ADD  = 2'b00;
    localparam logic [1:0] c_ALU_SUB  = 2'b01;
    localparam logic [1:0] c_ALU_AND  = 2'b10;
    localparam logic [1:0] c_ALU_PASS = 2'b11;

endpackage

`default_nettype wire

// File: rtl/ins_decode.sv
// ============================================================================
// Module      : ins_decode
// Description : Combinational decode of the latched instruction word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ins_decode
    import cpu_pkg::*;
(
    input  logic [15:0] ir,
    output logic [1:0]  alu_op,
    output logic        writes_rf,
    output logic        is_beq,
    output logic        is_hlt
);

    logic [2:0] w_opcode;
    logic       w_unused_bits;

    assign w_opcode = ir[10:8];
    // Upper bits and the immediate/offset field belong to the datapath only.
    assign w_unused_bits = &{1'b0, ir[15:11], ir[7:0]};

    always_comb begin
        alu_op    = c_ALU_ADD;
        writes_rf = 1'b0;
        is_beq    = 1'b0;
        is_hlt    = 1'b0;
        case (w_opcode)
            c_OP_ADD: begin alu_op = c_ALU_ADD;  writes_rf = 1'b1; end
            c_OP_SUB: begin alu_op = c_ALU_SUB;  writes_rf = 1'b1; end
            c_OP_AND: begin alu_op = c_ALU_AND;  writes_rf = 1'b1; end
            c_OP_LDI: begin alu_op = c_ALU_PASS; writes_rf = 1'b1; end
            c_OP_BEQ: is_beq = 1'b1;
            c_OP_HLT: is_hlt = 1'b1;
            default:  ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/cpu_ctrl.sv
// ============================================================================
// Module      : cpu_ctrl
// Description : Multi-cycle CPU control FSM (FETCH/DECODE/EXEC/WB) with
//               registered datapath controls and a retired-instruction count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_ctrl
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        single,
    input  logic [15:0] INS,
    input  logic        alu_eq,
    output logic [15:0] IR,
    output logic [1:0]  alu_op,
    output logic        rf_we,
    output logic        pc_tick,
    output logic        jmp_taken,
    output logic        pc_clr,
    output logic        busy,
    output logic        halted,
    output logic [7:0]  retired
);

    logic [2:0]  r_state;
    logic [15:0] r_ir;
    logic [1:0]  r_alu_op;
    logic        r_rf_we;
    logic        r_pc_tick;
    logic        r_taken;
    logic        r_busy;
    logic        r_halted;
    logic [7:0]  r_retired;

    logic [1:0]  w_alu_op;
    logic        w_writes_rf;
    logic        w_is_beq;
    logic        w_is_hlt;

    ins_decode u_ins_decode (
        .ir        (r_ir),
        .alu_op    (w_alu_op),
        .writes_rf (w_writes_rf),
        .is_beq    (w_is_beq),
        .is_hlt    (w_is_hlt)
    );

    // Outputs are set on the edge entering the state they belong to, so each
    // is a flop and matches the state register cycle for cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_ir      <= 16'h0000;
            r_alu_op  <= c_ALU_ADD;
            r_rf_we   <= 1'b0;
            r_pc_tick <= 1'b0;
            r_taken   <= 1'b0;
            r_busy    <= 1'b0;
            r_halted  <= 1'b0;
            r_retired <= 8'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (run) begin
                        r_state <= c_ST_FETCH;
                        r_busy  <= 1'b1;
                    end
                end
                c_ST_FETCH: begin
                    r_ir    <= INS;
                    r_state <= c_ST_DECODE;
                end
                c_ST_DECODE: begin
                    if (w_is_hlt) begin
                        r_state  <= c_ST_HALT;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                    end else begin
                        r_state  <= c_ST_EXEC;
                        r_alu_op <= w_alu_op;
                    end
                end
                c_ST_EXEC: begin
                    r_state   <= c_ST_WB;
                    r_taken   <= w_is_beq & alu_eq;
                    r_rf_we   <= w_writes_rf;
                    r_pc_tick <= 1'b1;
                end
                c_ST_WB: begin
                    r_alu_op  <= c_ALU_ADD;
                    r_rf_we   <= 1'b0;
                    r_pc_tick <= 1'b0;
                    r_taken   <= 1'b0;
                    r_retired <= r_retired + 8'd1;
                    if (single || !run) begin
                        r_state <= c_ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= c_ST_FETCH;
                    end
                end
                c_ST_HALT: begin
                    r_state <= c_ST_HALT;
                end
                default: begin
                    r_state  <= c_ST_IDLE;
                    r_busy   <= 1'b0;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign IR        = r_ir;
    assign alu_op    = r_alu_op;
    assign rf_we     = r_rf_we;
    assign pc_tick   = r_pc_tick;
    assign jmp_taken = r_taken;
    assign busy      = r_busy;
    assign halted    = r_halted;
    assign retired   = r_retired;
    // PC clears on the same edge the controller resets.
    assign pc_clr    = ~rst_n;

endmodule

`default_nettype wire

// File: tb/tb_cpu_ctrl.sv
// ============================================================================
// Module      : tb_cpu_ctrl
// Description : Directed table-driven bench for cpu_ctrl plus hand-written
//               halt, single-step, reset-in-WB and counter-wrap sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        single;
    logic [15:0] INS;
    logic        alu_eq;
    logic [15:0] IR;
    logic [1:0]  alu_op;
    logic        rf_we;
    logic        pc_tick;
    logic        jmp_taken;
    logic        pc_clr;
    logic        busy;
    logic        halted;
    logic [7:0]  retired;

    int total;
    int bad;

    cpu_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .single    (single),
        .INS       (INS),
        .alu_eq    (alu_eq),
        .IR        (IR),
        .alu_op    (alu_op),
        .rf_we     (rf_we),
        .pc_tick   (pc_tick),
        .jmp_taken (jmp_taken),
        .pc_clr    (pc_clr),
        .busy      (busy),
        .halted    (halted),
        .retired   (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        run;
        logic        single;
        logic [15:0] ins;
        logic        eq;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[$];

    // Output bundle: busy,halted,rf_we,pc_tick,jmp,alu_op[2],IR[16],retired[8],pc_clr
    function automatic logic [31:0] pack(input logic b, input logic h, input logic we,
                                         input logic tk, input logic j, input logic [1:0] op,
                                         input logic [15:0] ir, input logic [7:0] ret,
                                         input logic clr);
        return {b, h, we, tk, j, op, ir, ret, clr};
    endfunction

    function automatic logic [31:0] observed();
        return {busy, halted, rf_we, pc_tick, jmp_taken, alu_op, IR, retired, pc_clr};
    endfunction

    task automatic addv(input logic r, input logic ru, input logic s, input logic [15:0] ins,
                        input logic eq, input logic b, input logic h, input logic we,
                        input logic tk, input logic j, input logic [1:0] op,
                        input logic [15:0] ir, input logic [7:0] ret);
        vec_t v;
        v.rst_n  = r;
        v.run    = ru;
        v.single = s;
        v.ins    = ins;
        v.eq     = eq;
        v.exp    = pack(b, h, we, tk, j, op, ir, ret, ~r);
        vt.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        run    = 1'b0;
        single = 1'b0;
        INS    = 16'h0000;
        alu_eq = 1'b0;

        //     rst run sgl ins      eq | busy hlt we tk jmp op     ir       ret
        addv(0, 0, 0, 16'h0000, 0,  0, 0, 0, 0, 0, 2'b00, 16'h0000, 8'd0); // reset
        addv(1, 1, 0, 16'h0100, 0,  1, 0, 0, 0, 0, 2'b00, 16'h0000, 8'd0); // FETCH
        addv(1, 1, 0, 16'h0100, 0,  1, 0, 0, 0, 0, 2'b00, 16'h0100, 8'd0); // DECODE
        addv(1, 1, 0, 16'h0100, 0,  1, 0, 0, 0, 0, 2'b00, 16'h0100, 8'd0); // EXEC
        addv(1, 1, 0, 16'h0100, 0,  1, 0, 1, 1, 0, 2'b00, 16'h0100, 8'd0); // WB ADD
        addv(1, 1, 0, 16'h0430, 0,  1, 0, 0, 0, 0, 2'b00, 16'h0100, 8'd1);
        addv(1, 1, 0, 16'h0430, 0,  1, 0, 0, 0, 0, 2'b00, 16'h0430, 8'd1);
        addv(1, 1, 0, 16'h0430, 0,  1, 0, 0, 0, 0, 2'b00, 16'h0430, 8'd1);
        addv(1, 1, 0, 16'h0430, 1,  1, 0, 0, 1, 1, 2'b00, 16'h0430, 8'd1); // WB BEQ taken
        addv(1, 1, 0, 16'h0430, 1,  1, 0, 0, 0, 0, 2'b00, 16'h0430, 8'd2);
        addv(1, 1, 0, 16'h0430, 1,  1, 0, 0, 0, 0, 2'b00, 16'h0430, 8'd2);
        addv(1, 1, 0, 16'h0430, 1,  1, 0, 0, 0, 0, 2'b00, 16'h0430, 8'd2);
        addv(1, 1, 0, 16'h0430, 0,  1, 0, 0, 1, 0, 2'b00, 16'h0430, 8'd2); // WB BEQ not taken
        addv(1, 1, 0, 16'h0200, 0,  1, 0, 0, 0, 0, 2'b00, 16'h0430, 8'd3);
        addv(1, 1, 0, 16'h0200, 0,  1, 0, 0, 0, 0, 2'b00, 16'h0200, 8'd3);
        addv(1, 1, 0, 16'h0200, 0,  1, 0, 0, 0, 0, 2'b01, 16'h0200, 8'd3); // EXEC SUB
        addv(1, 1, 0, 16'h0200, 0,  1, 0, 1, 1, 0, 2'b01, 16'h0200, 8'd3); // WB SUB
        addv(1, 0, 0, 16'h0550, 0,  0, 0, 0, 0, 0, 2'b00, 16'h0200, 8'd4); // run=0 -> IDLE
        addv(1, 0, 0, 16'h0550, 0,  0, 0, 0, 0, 0, 2'b00, 16'h0200, 8'd4); // stays IDLE
        addv(1, 1, 0, 16'h0550, 0,  1, 0, 0, 0, 0, 2'b00, 16'h0200, 8'd4);
        addv(1, 1, 0, 16'h0550, 0,  1, 0, 0, 0, 0, 2'b00, 16'h0550, 8'd4);
        addv(1, 0, 0, 16'h0550, 0,  1, 0, 0, 0, 0, 2'b11, 16'h0550, 8'd4); // run drop ignored
        addv(1, 0, 0, 16'h0550, 0,  1, 0, 1, 1, 0, 2'b11, 16'h0550, 8'd4); // WB LDI
        addv(1, 0, 0, 16'h0550, 0,  0, 0, 0, 0, 0, 2'b00, 16'h0550, 8'd5);
        addv(1, 1, 0, 16'h0B31, 0,  1, 0, 0, 0, 0, 2'b00, 16'h0550, 8'd5);
        addv(1, 1, 0, 16'h0B31, 0,  1, 0, 0, 0, 0, 2'b00, 16'h0B31, 8'd5);
        addv(1, 1, 0, 16'h0B31, 0,  1, 0, 0, 0, 0, 2'b10, 16'h0B31, 8'd5); // EXEC AND
        addv(1, 1, 0, 16'h0B31, 0,  1, 0, 1, 1, 0, 2'b10, 16'h0B31, 8'd5);
        addv(1, 1, 0, 16'h0600, 0,  1, 0, 0, 0, 0, 2'b00, 16'h0B31, 8'd6);
        addv(1, 1, 0, 16'h0600, 0,  1, 0, 0, 0, 0, 2'b00, 16'h0600, 8'd6);
        addv(1, 1, 0, 16'h0600, 0,  1, 0, 0, 0, 0, 2'b00, 16'h0600, 8'd6);
        addv(1, 1, 0, 16'h0600, 0,  1, 0, 0, 1, 0, 2'b00, 16'h0600, 8'd6); // WB NOP(110)
        addv(1, 0, 0, 16'h0600, 0,  0, 0, 0, 0, 0, 2'b00, 16'h0600, 8'd7);

        foreach (vt[i]) begin
            rst_n  = vt[i].rst_n;
            run    = vt[i].run;
            single = vt[i].single;
            INS    = vt[i].ins;
            alu_eq = vt[i].eq;
            tick();
            check($sformatf("vec%0d", i), observed(), vt[i].exp);
        end

        // HLT: halts after DECODE and ignores run afterwards
        INS = 16'h0700;
        run = 1'b1;
        tick();
        tick();
        check("hlt_decode", {30'd0, busy, halted}, {30'd0, 1'b1, 1'b0});
        tick();
        for (int k = 0; k < 8; k++) begin
            run    = k[0];
            single = k[1];
            tick();
            check($sformatf("halt%0d", k), {20'd0, busy, halted, rf_we, pc_tick, retired},
                  {20'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd7});
        end

        // Reset escapes HALT
        single = 1'b0;
        run    = 1'b0;
        do_reset();
        check("halt_reset", {24'd0, busy, halted, retired[5:0]}, 32'd0);

        // Single-step: IDLE after each WB
        single = 1'b1;
        run    = 1'b1;
        INS    = 16'h0100;
        for (int n = 1; n <= 2; n++) begin
            repeat (4) tick();
            check($sformatf("ss_wb%0d", n), {30'd0, rf_we, pc_tick}, 32'd3);
            tick();
            check($sformatf("ss_idle%0d", n), {23'd0, busy, retired}, {23'd0, 1'b0, 8'(n)});
        end

        // Reset asserted during WB of LDI
        single = 1'b0;
        run    = 1'b0;
        do_reset();
        run = 1'b1;
        INS = 16'h0550;
        repeat (4) tick();
        check("ldi_wb", {28'd0, rf_we, pc_tick, alu_op}, {28'd0, 1'b1, 1'b1, 2'b11});
        rst_n = 1'b0;
        #1;
        check("pc_clr_rst", {31'd0, pc_clr}, 32'd1);
        tick();
        check("rst_wb", observed(), pack(0, 0, 0, 0, 0, 2'b00, 16'h0000, 8'd0, 1'b1));
        rst_n = 1'b1;
        run   = 1'b0;
        tick();
        check("rst_after", observed(), pack(0, 0, 0, 0, 0, 2'b00, 16'h0000, 8'd0, 1'b0));

        // 256 back-to-back NOPs: pc_tick every 4th cycle, retired wraps
        do_reset();
        INS = 16'h0000;
        run = 1'b1;
        for (int n = 1; n <= 1025; n++) begin
            tick();
            check($sformatf("nop_tick%0d", n), {31'd0, pc_tick}, {31'd0, (n % 4) == 0});
            if (n == 1021)
                check("nop_ret255", {24'd0, retired}, 32'd255);
        end
        check("nop_wrap", {24'd0, retired}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
